fetch_unit: RTL and testbench

- IF-stage controller and IF/ID pipeline register for the 5-stage pipelined core.
- Consumes the stall requests the ID-stage hazard logic produces and the branch redirect from EX.
- Owns the PC, drives the synchronous instruction-memory read, and presents instr/PC/valid to ID.
- Keeps a one-entry hold buffer so a stalled instruction survives BRAM read-data changes.
- Exposes saturating stall/flush event counters.

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_unit_sat_counter.sv | 36 +++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the IF stage: datapath width, reset PC default,
// the canonical NOP encoding and the IF/ID register bundle.
package fetch_unit_pkg;

  localparam int unsigned PKG_XLEN     = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef struct packed {
    logic [PKG_XLEN-1:0] instr;
    logic [PKG_XLEN-1:0] pc;
    logic [PKG_XLEN-1:0] pc_plus4;
    logic                valid;
  } if_id_t;

endpackage

// File: rtl/fetch_unit_sat_counter.sv
// Saturating event counter.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high clear
//   inc   - add one this cycle (ignored once the count is all-ones)
//   count - current count
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// IF-stage controller and IF/ID pipeline register.
// Owns the PC, issues synchronous instruction-memory reads and presents
// instruction/PC/valid to ID. A one-entry hold buffer keeps the stalled
// instruction stable while the memory read data changes underneath it.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   stall_IF                   - hold PC and IF/ID this cycle
//   branch_taken_EX/_target_EX - redirect from EX (also squashes IF/ID)
//   imem_addr/en/rdata         - instruction memory, data one cycle after addr
//   instr/pc/pc_plus4/valid_IFID - IF/ID register outputs to ID
//   stall_count, flush_count   - saturating event counters
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = PKG_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_IF,
  input  logic             branch_taken_EX,
  input  logic [XLEN-1:0]  branch_target_EX,
  output logic [XLEN-1:0]  imem_addr,
  output logic             imem_en,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  instr_IFID,
  output logic [XLEN-1:0]  pc_IFID,
  output logic [XLEN-1:0]  pc_plus4_IFID,
  output logic             valid_IFID,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] pc_d_q, pc_d_d;
  logic            valid_d_q, valid_d_d;
  logic            hold_valid_q, hold_valid_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;

  if_id_t if_id;

  // Priority: redirect > stall > advance (reset handled in the register).
  always_comb begin
    pc_f_d       = pc_f_q;
    pc_d_d       = pc_d_q;
    valid_d_d    = valid_d_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    if (branch_taken_EX) begin
      // EX branch is older than the stalled ID instruction, so it wins.
      pc_f_d       = {branch_target_EX[XLEN-1:2], 2'b00};
      valid_d_d    = 1'b0;
      hold_valid_d = 1'b0;
    end else if (stall_IF) begin
      // Capture only on the first stall edge; later edges see stale rdata.
      if (!hold_valid_q) begin
        hold_instr_d = imem_rdata;
        hold_valid_d = 1'b1;
      end
    end else begin
      pc_d_d       = pc_f_q;
      valid_d_d    = 1'b1;
      pc_f_d       = pc_f_q + XLEN'(4);
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q       <= RESET_PC;
      pc_d_q       <= '0;
      valid_d_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
    end else begin
      pc_f_q       <= pc_f_d;
      pc_d_q       <= pc_d_d;
      valid_d_q    <= valid_d_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  // Reset forces the visible outputs in the reset cycle itself, not only after.
  assign imem_addr = reset ? RESET_PC : pc_f_q;
  assign imem_en   = !stall_IF || branch_taken_EX;

  always_comb begin
    if_id.instr    = hold_valid_q ? hold_instr_q : imem_rdata;
    if_id.pc       = pc_d_q;
    if_id.pc_plus4 = pc_d_q + XLEN'(4);
    if_id.valid    = valid_d_q && !reset;
  end

  assign instr_IFID    = if_id.instr;
  assign pc_IFID       = if_id.pc;
  assign pc_plus4_IFID = if_id.pc_plus4;
  assign valid_IFID    = if_id.valid;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_IF && !branch_taken_EX),
    .count (stall_count)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (branch_taken_EX),
    .count (flush_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_IF = 1'b0;
  logic        branch_taken_EX = 1'b0;
  logic [31:0] branch_target_EX = 32'h0;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr_IFID, pc_IFID, pc_plus4_IFID;
  logic        valid_IFID;
  logic [31:0] stall_count, flush_count;

  // Second instance with 2-bit counters to reach saturation quickly.
  logic        reset2 = 1'b1;
  logic        stall2 = 1'b0;
  logic        branch2 = 1'b0;
  logic [31:0] imem_addr2, instr2, pc2, pc4_2;
  logic        imem_en2, valid2;
  logic [1:0]  stall_count2, flush_count2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk              (clk),
    .reset            (reset),
    .stall_IF         (stall_IF),
    .branch_taken_EX  (branch_taken_EX),
    .branch_target_EX (branch_target_EX),
    .imem_addr        (imem_addr),
    .imem_en          (imem_en),
    .imem_rdata       (imem_rdata),
    .instr_IFID       (instr_IFID),
    .pc_IFID          (pc_IFID),
    .pc_plus4_IFID    (pc_plus4_IFID),
    .valid_IFID       (valid_IFID),
    .stall_count      (stall_count),
    .flush_count      (flush_count)
  );

  fetch_unit #(
    .CNT_W (2)
  ) u_sat (
    .clk              (clk),
    .reset            (reset2),
    .stall_IF         (stall2),
    .branch_taken_EX  (branch2),
    .branch_target_EX (32'h0000_0040),
    .imem_addr        (imem_addr2),
    .imem_en          (imem_en2),
    .imem_rdata       (32'h0),
    .instr_IFID       (instr2),
    .pc_IFID          (pc2),
    .pc_plus4_IFID    (pc4_2),
    .valid_IFID       (valid2),
    .stall_count      (stall_count2),
    .flush_count      (flush_count2)
  );

  // BRAM model: mem[a] = a + 1. When not enabled the output is scrambled so
  // only the hold buffer can keep instr_IFID stable across a stall.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem_addr + 32'd1;
    else         imem_rdata <= $urandom;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    step();
    chk("rst_valid_in_reset", 32'(valid_IFID), 32'h0);
    chk("rst_addr_in_reset", imem_addr, 32'h0);
    step();
    reset = 1'b0;
    #1;
    chk("rst_valid_after", 32'(valid_IFID), 32'h0);
    chk("rst_addr_after", imem_addr, 32'h0);
    chk("rst_stall_cnt", stall_count, 32'h0);
    chk("rst_flush_cnt", flush_count, 32'h0);

    // Free run
    step();
    chk("run0_pc", pc_IFID, 32'h0);
    chk("run0_valid", 32'(valid_IFID), 32'h1);
    chk("run0_instr", instr_IFID, 32'h1);
    chk("run0_pc4", pc_plus4_IFID, 32'h4);
    chk("run0_addr", imem_addr, 32'h4);
    step();
    chk("run1_pc", pc_IFID, 32'h4);
    chk("run1_instr", instr_IFID, 32'h5);
    step();
    chk("run2_pc", pc_IFID, 32'h8);
    chk("run2_instr", instr_IFID, 32'h9);
    chk("run2_addr", imem_addr, 32'hC);

    // Three-cycle stall
    stall_IF = 1'b1;
    #1;
    chk("stall_en_low", 32'(imem_en), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_instr", instr_IFID, 32'h9);
      chk("stall_pc", pc_IFID, 32'h8);
      chk("stall_addr", imem_addr, 32'hC);
      chk("stall_valid", 32'(valid_IFID), 32'h1);
    end
    chk("stall_cnt3", stall_count, 32'h3);
    stall_IF = 1'b0;
    step();
    chk("unstall_pc", pc_IFID, 32'hC);
    chk("unstall_instr", instr_IFID, 32'hD);
    chk("unstall_cnt", stall_count, 32'h3);

    // Redirect to 0x100
    branch_taken_EX = 1'b1;
    branch_target_EX = 32'h100;
    step();
    chk("redir_valid", 32'(valid_IFID), 32'h0);
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_flush_cnt", flush_count, 32'h1);
    branch_taken_EX = 1'b0;
    step();
    chk("redir_tgt_pc", pc_IFID, 32'h100);
    chk("redir_tgt_valid", 32'(valid_IFID), 32'h1);
    chk("redir_tgt_instr", instr_IFID, 32'h101);

    // Stall (captures 0x101) then redirect+stall together to 0x200
    stall_IF = 1'b1;
    step();
    chk("pre_both_instr", instr_IFID, 32'h101);
    chk("pre_both_stall_cnt", stall_count, 32'h4);
    branch_taken_EX = 1'b1;
    branch_target_EX = 32'h200;
    #1;
    chk("both_en_high", 32'(imem_en), 32'h1);
    step();
    chk("both_valid", 32'(valid_IFID), 32'h0);
    chk("both_addr", imem_addr, 32'h200);
    chk("both_stall_cnt", stall_count, 32'h4);
    chk("both_flush_cnt", flush_count, 32'h2);
    chk("both_hold_clear", instr_IFID, 32'h105);
    branch_taken_EX = 1'b0;
    stall_IF = 1'b0;
    step();
    chk("both_tgt_pc", pc_IFID, 32'h200);
    chk("both_tgt_instr", instr_IFID, 32'h201);

    // Misaligned target is word-aligned
    branch_taken_EX = 1'b1;
    branch_target_EX = 32'h103;
    step();
    chk("align_addr", imem_addr, 32'h100);
    branch_taken_EX = 1'b0;
    step();
    chk("align_pc", pc_IFID, 32'h100);
    chk("align_instr", instr_IFID, 32'h101);
    chk("align_flush_cnt", flush_count, 32'h3);

    // PC wrap
    branch_taken_EX = 1'b1;
    branch_target_EX = 32'hFFFF_FFFC;
    step();
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    branch_taken_EX = 1'b0;
    step();
    chk("wrap_pc_top", pc_IFID, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4_IFID, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_instr_top", instr_IFID, 32'hFFFF_FFFD);
    step();
    chk("wrap_pc0", pc_IFID, 32'h0);
    chk("wrap_instr0", instr_IFID, 32'h1);

    // Reset mid-stall with a redirect pending
    stall_IF = 1'b1;
    step();
    reset = 1'b1;
    branch_taken_EX = 1'b1;
    branch_target_EX = 32'h300;
    step();
    chk("mrst_valid", 32'(valid_IFID), 32'h0);
    chk("mrst_addr", imem_addr, 32'h0);
    chk("mrst_pc", pc_IFID, 32'h0);
    chk("mrst_stall_cnt", stall_count, 32'h0);
    chk("mrst_flush_cnt", flush_count, 32'h0);
    reset = 1'b0;
    branch_taken_EX = 1'b0;
    stall_IF = 1'b0;
    #1;
    chk("mrst_valid_after", 32'(valid_IFID), 32'h0);
    step();
    chk("mrst_run_pc", pc_IFID, 32'h0);
    chk("mrst_run_valid", 32'(valid_IFID), 32'h1);
    chk("mrst_run_instr", instr_IFID, 32'h1);

    // Saturation on the 2-bit instance
    reset2 = 1'b0;
    stall2 = 1'b1;
    step();
    chk("sat_stall1", 32'(stall_count2), 32'h1);
    step();
    chk("sat_stall2", 32'(stall_count2), 32'h2);
    step();
    chk("sat_stall3", 32'(stall_count2), 32'h3);
    step();
    chk("sat_stall_hold", 32'(stall_count2), 32'h3);
    step();
    chk("sat_stall_hold2", 32'(stall_count2), 32'h3);
    branch2 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("sat_flush", 32'(flush_count2), (i > 3) ? 32'h3 : 32'(i));
      chk("sat_flush_stall_cnt", 32'(stall_count2), 32'h3);
    end
    reset2 = 1'b1;
    step();
    chk("sat_rst_stall", 32'(stall_count2), 32'h0);
    chk("sat_rst_flush", 32'(flush_count2), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
